// File: rtl/sequence_generator.sv
// Move-sequence generator for the memory game: fills the sequence BRAM with one-hot
// key codes drawn from a free-running LFSR, either as a whole new sequence or one move appended.
module sequence_generator #(
  parameter int                NUM_KEYS  = 4,
  parameter int                ADDR_W    = 5,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W:0]     length,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     seq_len,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [NUM_KEYS-1:0] mem_data,
  output logic                mem_wren
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [IDX_W:0]   NUM_KEYS_C = (IDX_W + 1)'(NUM_KEYS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [CNT_W-1:0]     seq_len_q, seq_len_d;
  logic [IDX_W-1:0]     key_q, key_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 last_valid_q, last_valid_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [NUM_KEYS-1:0]  mem_data_q, mem_data_d;
  logic                 mem_wren_q, mem_wren_d;

  logic [IDX_W-1:0]     cand;
  logic                 cand_ok;
  logic [CNT_W-1:0]     ptr_next;
  logic [CNT_W-1:0]     target_full;
  logic                 lfsr_fb;

  function automatic logic [NUM_KEYS-1:0] onehot(input logic [IDX_W-1:0] k);
    onehot = {{(NUM_KEYS - 1){1'b0}}, 1'b1} << k;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    target_d     = target_q;
    seq_len_d    = seq_len_q;
    key_d        = key_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    ovf_flag_d   = ovf_flag_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    ptr_next = ptr_q + {{(CNT_W - 1){1'b0}}, 1'b1};
    cand     = lfsr_q[IDX_W-1:0];
    // A candidate is usable only when it names a real key and, if enabled, differs from the previous move.
    cand_ok  = ({1'b0, cand} < NUM_KEYS_C) && !(NO_REPEAT && last_valid_q && (cand == last_q));
    target_full = (length > DEPTH) ? DEPTH : length;

    if (seed_load) begin
      lfsr_d = (seed == {LFSR_W{1'b0}}) ? SEED : seed;
    end else begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!mode) begin
            ptr_d        = {CNT_W{1'b0}};
            target_d     = target_full;
            seq_len_d    = {CNT_W{1'b0}};
            last_valid_d = 1'b0;
            ovf_flag_d   = 1'b0;
            state_d      = (target_full == {CNT_W{1'b0}}) ? S_DONE : S_GEN;
          end else if (seq_len_q == DEPTH) begin
            ovf_flag_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            ptr_d      = seq_len_q;
            target_d   = seq_len_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            ovf_flag_d = 1'b0;
            state_d    = S_GEN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GEN: begin
        if (cand_ok) begin
          key_d   = cand;
          state_d = S_WRITE;
        end else begin
          state_d = S_GEN;
        end
      end
      S_WRITE: begin
        last_d       = key_q;
        last_valid_d = 1'b1;
        ptr_d        = ptr_next;
        seq_len_d    = ptr_next;
        mem_addr_d   = ptr_q[ADDR_W-1:0];
        mem_data_d   = onehot(key_q);
        if (ptr_next == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_GEN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are a registered decode of the current state.
    busy_d     = (state_q != S_IDLE);
    done_d     = (state_q == S_DONE);
    overflow_d = (state_q == S_DONE) && ovf_flag_q;
    mem_wren_d = (state_q == S_WRITE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      ptr_q        <= {CNT_W{1'b0}};
      target_q     <= {CNT_W{1'b0}};
      seq_len_q    <= {CNT_W{1'b0}};
      key_q        <= {IDX_W{1'b0}};
      last_q       <= {IDX_W{1'b0}};
      last_valid_q <= 1'b0;
      ovf_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_data_q   <= {NUM_KEYS{1'b0}};
      mem_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      ptr_q        <= ptr_d;
      target_q     <= target_d;
      seq_len_q    <= seq_len_d;
      key_q        <= key_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      ovf_flag_q   <= ovf_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wren_q   <= mem_wren_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign seq_len  = seq_len_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: an LFSR shadow predicts every BRAM write per request,
// which is queued and compared against the writes seen on two differently-parameterised DUTs.
module tb_sequence_generator;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset, start, start3, mode, seed_load;
  logic [5:0]  length;
  logic [15:0] seed;

  logic busy, done, overflow, mem_wren;
  logic [5:0] seq_len;
  logic [4:0] mem_addr;
  logic [3:0] mem_data;
  logic busy3, done3, overflow3, mem_wren3;
  logic [5:0] seq_len3;
  logic [4:0] mem_addr3;
  logic [2:0] mem_data3;

  sequence_generator dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .length(length),
    .seed_load(seed_load), .seed(seed), .busy(busy), .done(done), .overflow(overflow),
    .seq_len(seq_len), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren)
  );

  sequence_generator #(.NUM_KEYS(3), .NO_REPEAT(1'b0)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .mode(mode), .length(length),
    .seed_load(seed_load), .seed(seed), .busy(busy3), .done(done3), .overflow(overflow3),
    .seq_len(seq_len3), .mem_addr(mem_addr3), .mem_data(mem_data3), .mem_wren(mem_wren3)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; logic [15:0] data; } wr_t;
  typedef struct {
    int inst; bit mode; int len; bit do_seed; logic [15:0] sd; bit mid; int exp_len; bit exp_ovf;
  } vec_t;

  wr_t exp0[$], exp1[$], obs0[$], obs1[$];
  logic [15:0] last_data[$], run_a[$], run_b[$];
  logic [15:0] m_lfsr;
  int  m_len[2], m_last[2];
  bit  m_lv[2];
  int  n_checks = 0, n_fail = 0;
  vec_t vecs[14];

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always @(posedge clock) begin
    if (reset) m_lfsr <= SEED;
    else if (seed_load) m_lfsr <= (seed == 16'd0) ? SEED : seed;
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(negedge clock) begin
    if (mem_wren === 1'b1) obs0.push_back('{int'(mem_addr), 16'(mem_data)});
    if (mem_wren3 === 1'b1) obs1.push_back('{int'(mem_addr3), 16'(mem_data3)});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic dn(input int inst);
    return (inst == 0) ? done : done3;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start = v; else start3 = v;
  endtask

  // Expected writes and start-to-done step count for one request, from the LFSR value now held.
  task automatic predict(input int inst, input bit md, input int len, output int steps, output bit ovf);
    logic [15:0] v;
    int ptr, target, s, k, nk;
    bit norep;
    nk = (inst == 0) ? 4 : 3;
    norep = (inst == 0);
    ovf = 1'b0;
    ptr = 0;
    target = 0;
    if (!md) begin
      target = (len > DEPTH) ? DEPTH : len;
      m_len[inst] = 0;
      m_lv[inst] = 1'b0;
    end else if (m_len[inst] == DEPTH) begin
      ovf = 1'b1;
    end else begin
      ptr = m_len[inst];
      target = ptr + 1;
    end
    v = lfsr_next(m_lfsr);
    s = 1;
    while (ptr < target && s < 5000) begin
      k = int'(v[1:0]);
      if (k < nk && !(norep && m_lv[inst] && k == m_last[inst])) begin
        if (inst == 0) exp0.push_back('{ptr, 16'h0001 << k});
        else exp1.push_back('{ptr, 16'h0001 << k});
        m_last[inst] = k;
        m_lv[inst] = 1'b1;
        ptr++;
        m_len[inst] = ptr;
        v = lfsr_next(lfsr_next(v));
        s += 2;
      end else begin
        v = lfsr_next(v);
        s += 1;
      end
    end
    steps = s + 1;
  endtask

  task automatic compare_writes(input int inst);
    wr_t e[$], o[$];
    if (inst == 0) begin e = exp0; o = obs0; end
    else begin e = exp1; o = obs1; end
    check("write_count", o.size(), e.size());
    last_data.delete();
    for (int i = 0; i < o.size() && i < e.size(); i++) begin
      check("write_addr", o[i].addr, e[i].addr);
      check("write_data", o[i].data, e[i].data);
      last_data.push_back(o[i].data);
    end
    if (inst == 0) begin exp0.delete(); obs0.delete(); end
    else begin exp1.delete(); obs1.delete(); end
  endtask

  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; start3 = 1'b0; seed_load = 1'b0; mode = 1'b0;
    length = 6'd0; seed = 16'd0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin m_len[i] = 0; m_lv[i] = 1'b0; m_last[i] = 0; end
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
  endtask

  task automatic do_op(input vec_t v);
    int steps_exp, n;
    bit ovf_exp;
    if (v.do_seed) begin
      seed_load = 1'b1; seed = v.sd;
      step();
      seed_load = 1'b0;
    end
    mode = v.mode;
    length = 6'(v.len);
    predict(v.inst, v.mode, v.len, steps_exp, ovf_exp);
    set_start(v.inst, 1'b1);
    step();
    set_start(v.inst, 1'b0);
    n = 1;
    while (dn(v.inst) !== 1'b1 && n < 4000) begin
      if (v.mid && n == 3) begin mode = 1'b1; set_start(v.inst, 1'b1); end
      step();
      set_start(v.inst, 1'b0);
      n++;
    end
    check("latency", n, steps_exp);
    check("overflow", (v.inst == 0) ? overflow : overflow3, ovf_exp);
    check("overflow_expected", ovf_exp, v.exp_ovf);
    check("seq_len", (v.inst == 0) ? seq_len : seq_len3, v.exp_len);
    step();
    check("done_one_cycle", dn(v.inst), 1'b0);
    check("busy_after", (v.inst == 0) ? busy : busy3, 1'b0);
    compare_writes(v.inst);
  endtask

  initial begin
    int se;
    bit so;
    vecs[0]  = '{0, 1'b0, 5,  1'b0, 16'h0000, 1'b0, 5,  1'b0};
    vecs[1]  = '{0, 1'b0, 8,  1'b1, 16'h1234, 1'b0, 8,  1'b0};
    vecs[2]  = '{0, 1'b0, 0,  1'b0, 16'h0000, 1'b0, 0,  1'b0};
    vecs[3]  = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 1,  1'b0};
    vecs[4]  = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 2,  1'b0};
    vecs[5]  = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 3,  1'b0};
    vecs[6]  = '{0, 1'b0, 5,  1'b0, 16'h0000, 1'b1, 5,  1'b0};
    vecs[7]  = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 6,  1'b0};
    vecs[8]  = '{0, 1'b0, 40, 1'b0, 16'h0000, 1'b0, 32, 1'b0};
    vecs[9]  = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 32, 1'b1};
    vecs[10] = '{0, 1'b0, 32, 1'b1, 16'h0000, 1'b0, 32, 1'b0};
    vecs[11] = '{0, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 32, 1'b1};
    vecs[12] = '{1, 1'b0, 16, 1'b0, 16'h0000, 1'b0, 16, 1'b0};
    vecs[13] = '{1, 1'b1, 0,  1'b0, 16'h0000, 1'b0, 17, 1'b0};

    reset_dut();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_addr", mem_addr, 5'd0);
    check("rst_data", mem_data, 4'd0);
    check("rst_seq_len", seq_len, 6'd0);
    check("rst_seq_len3", seq_len3, 6'd0);

    for (int i = 0; i < 14; i++) do_op(vecs[i]);

    // Same seed and timing after reset must reproduce the same sequence.
    reset_dut();
    do_op('{0, 1'b0, 8, 1'b1, 16'h1234, 1'b0, 8, 1'b0});
    run_a = last_data;
    reset_dut();
    do_op('{0, 1'b0, 8, 1'b1, 16'h1234, 1'b0, 8, 1'b0});
    run_b = last_data;
    check("repeat_len", run_b.size(), 8);
    for (int i = 0; i < run_a.size() && i < run_b.size(); i++) check("repeat_word", run_b[i], run_a[i]);

    // A zero seed behaves as SEED.
    reset_dut();
    do_op('{0, 1'b0, 8, 1'b1, 16'h0000, 1'b0, 8, 1'b0});
    run_a = last_data;
    reset_dut();
    do_op('{0, 1'b0, 8, 1'b1, SEED, 1'b0, 8, 1'b0});
    run_b = last_data;
    check("seed0_len", run_b.size(), 8);
    for (int i = 0; i < run_a.size() && i < run_b.size(); i++) check("seed0_word", run_a[i], run_b[i]);

    // Reset while the generator is between writes aborts with no further writes.
    reset_dut();
    mode = 1'b0;
    length = 6'd4;
    predict(0, 1'b0, 4, se, so);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 200 && obs0.size() == 0; n++) step();
    check("abort_first_write", obs0.size() >= 1, 1'b1);
    if (obs0.size() >= 1 && exp0.size() >= 1) check("abort_first_data", obs0[0].data, exp0[0].data);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_len[0] = 0;
    m_lv[0] = 1'b0;
    exp0.delete();
    obs0.delete();
    repeat (10) step();
    check("abort_no_writes", obs0.size(), 0);
    check("abort_seq_len", seq_len, 6'd0);
    check("abort_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
